// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect input and the
// buffered instruction handed to decode. master = fetch stage, slave = its neighbours.
interface fetch_stage_if;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] inst_pc;
        logic        inst_signal;
    } if_id_t;

    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        id_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    if_id_t      if_id_state;

    modport master (
        output ireq_valid, ireq_addr, if_id_state,
        input  iresp_ok, iresp_data, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, if_id_state,
        output iresp_ok, iresp_data, id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read, one-entry output buffer to decode,
// redirects drain any in-flight read before fetching the new target.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t      state_q;
    logic [63:0] fetch_pc_q;
    logic [63:0] drain_addr_q;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;
    logic        inst_valid_q;
    logic [63:0] target;

    assign target = bus.redirect_pc & ~64'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect_valid) fetch_pc_q <= target;
                    state_q <= REQ;
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= target;
                        // Completed read can be dropped outright; a pending one must drain.
                        if (!bus.iresp_ok) begin
                            drain_addr_q <= fetch_pc_q;
                            state_q      <= DRAIN;
                        end
                    end else if (bus.iresp_ok) begin
                        inst_q       <= bus.iresp_data;
                        inst_pc_q    <= fetch_pc_q;
                        inst_valid_q <= 1'b1;
                        fetch_pc_q   <= fetch_pc_q + 64'd4;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q   <= target;
                        inst_valid_q <= 1'b0;
                        state_q      <= REQ;
                    end else if (bus.id_ready) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= REQ;
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) fetch_pc_q <= target;
                    if (bus.iresp_ok) state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The stale address lives in drain_addr_q so fetch_pc_q can track later redirects.
    assign bus.ireq_valid  = (state_q == REQ) || (state_q == DRAIN);
    assign bus.ireq_addr   = (state_q == DRAIN) ? drain_addr_q :
                             (state_q == REQ)   ? fetch_pc_q   : 64'd0;
    assign bus.if_id_state = {inst_q, inst_pc_q, inst_valid_q};
endmodule
